icache_cwf: RTL and testbench

ICACHE_CWF -- requirements
Module: icache_cwf

---
 rtl/icache_cwf.sv | 258 +++++++++++++++++++++++++
 tb/tb_icache_cwf.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_cwf.sv
// rtl/icache_cwf.sv - set-associative instruction cache with critical-word-first line fill
module icache_cwf #(
    parameter int WAYS   = 2,
    parameter int LINES  = 512,
    parameter int LINE_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_on,
    input  logic        new_request,
    input  logic [31:0] stage1_addr,
    input  logic [31:0] stage2_addr,
    input  logic        flush,
    input  logic        inv_req,
    output logic        inv_done,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        ready,
    output logic        mem_request,
    output logic [31:0] mem_addr,
    output logic [4:0]  mem_size,
    input  logic        mem_ack,
    input  logic        mem_data_valid,
    input  logic [31:0] mem_data
);
    localparam int OFF_W  = $clog2(LINE_W);
    localparam int IDX_W  = $clog2(LINES);
    localparam int IDX_LO = 2 + OFF_W;
    localparam int TAG_LO = IDX_LO + IDX_W;
    localparam int TAG_W  = 32 - TAG_LO;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REQ,
        S_FILL,
        S_DRAIN,
        S_INV
    } state_t;

    state_t state, state_n;

    // Storage: tags and valid bits per way/index, data per way/index/word
    logic [TAG_W-1:0] tag_mem   [WAYS][LINES];
    logic [LINES-1:0] valid_mem [WAYS];
    logic [31:0]      data_mem  [WAYS][LINES*LINE_W];

    // Registered read port, addressed by stage1_addr so it lines up with LOOKUP
    logic [TAG_W-1:0] tag_rd  [WAYS];
    logic [WAYS-1:0]  valid_rd;
    logic [31:0]      data_rd [WAYS];

    logic [IDX_W-1:0] idx1, idx2;
    logic [OFF_W-1:0] off1, off2, wr_off;
    logic [TAG_W-1:0] tag2;
    logic             unused_addr_bits;

    logic [WAYS-1:0]  vic_cnt;
    logic [WAYS-1:0]  victim;
    logic [OFF_W-1:0] beat_cnt;
    logic             flush_seen;
    logic [31:0]      cw_word;
    logic             cw_valid;
    logic             inv_pend;
    logic             inv_quiet;
    logic [IDX_W-1:0] inv_idx;

    logic [WAYS-1:0]  hit_vec;
    logic             hit;
    logic [31:0]      hit_word;
    logic             fill_beat;
    logic             fill_last;
    logic             inv_last;

    assign idx1 = stage1_addr[TAG_LO-1:IDX_LO];
    assign off1 = stage1_addr[IDX_LO-1:2];
    assign idx2 = stage2_addr[TAG_LO-1:IDX_LO];
    assign off2 = stage2_addr[IDX_LO-1:2];
    assign tag2 = stage2_addr[31:TAG_LO];
    assign unused_addr_bits = ^{stage1_addr[31:TAG_LO], stage1_addr[1:0], stage2_addr[1:0]};

    // Beats arrive critical word first, so the write offset wraps around the line
    assign wr_off    = off2 + beat_cnt;
    assign fill_beat = (state == S_FILL) && mem_data_valid;
    assign fill_last = fill_beat && (beat_cnt == OFF_W'(LINE_W - 1));
    assign inv_last  = (state == S_INV) && (inv_idx == IDX_W'(LINES - 1));

    assign mem_addr = {stage2_addr[31:2], 2'b00};
    assign mem_size = 5'(LINE_W - 1);

    // Tag compare across all ways; hits only count while the cache is enabled
    always_comb begin
        hit_vec  = '0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = icache_on && valid_rd[w] && (tag_rd[w] == tag2);
            if (hit_vec[w]) begin
                hit_word = hit_word | data_rd[w];
            end
        end
    end

    assign hit = |hit_vec;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; a request accepted in IDLE wins over a same-cycle invalidate
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (new_request && !inv_pend && !flush) begin
                    state_n = S_LOOKUP;
                end else if (inv_pend || inv_req) begin
                    state_n = S_INV;
                end
            end
            S_LOOKUP: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else if (hit) begin
                    state_n = new_request ? S_LOOKUP : S_IDLE;
                end else begin
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else if (mem_ack) begin
                    state_n = S_FILL;
                end
            end
            S_FILL: begin
                if (fill_last) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_n = (new_request && !flush) ? S_LOOKUP : S_IDLE;
            end
            S_INV: begin
                if (inv_last) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs; data_out is forced to zero whenever data_valid is low
    always_comb begin
        ready       = 1'b0;
        data_valid  = 1'b0;
        data_out    = '0;
        mem_request = 1'b0;
        inv_done    = 1'b0;
        case (state)
            S_IDLE: ready = !inv_pend;
            S_LOOKUP: begin
                ready = hit;
                if (hit && !flush) begin
                    data_valid = 1'b1;
                    data_out   = hit_word;
                end
            end
            S_REQ:   mem_request = !flush;
            S_DRAIN: ready = 1'b1;
            S_INV:   inv_done = inv_last && !inv_quiet;
            default: ready = 1'b0;
        endcase
        if (cw_valid && !flush) begin
            data_valid = 1'b1;
            data_out   = cw_word;
        end
    end

    // Control registers: victim rotation, beat count, critical word, invalidate bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            vic_cnt    <= WAYS'(1);
            victim     <= WAYS'(1);
            beat_cnt   <= '0;
            flush_seen <= 1'b0;
            cw_word    <= '0;
            cw_valid   <= 1'b0;
            inv_pend   <= 1'b1;
            inv_quiet  <= 1'b1;
            inv_idx    <= '0;
        end else begin
            vic_cnt <= (vic_cnt << 1) | (vic_cnt >> (WAYS - 1));
            if (state == S_LOOKUP && state_n == S_REQ) begin
                victim <= vic_cnt;
            end
            if (state == S_REQ && state_n == S_FILL) begin
                beat_cnt   <= '0;
                flush_seen <= 1'b0;
            end else begin
                if (fill_beat) begin
                    beat_cnt <= beat_cnt + OFF_W'(1);
                end
                if ((state == S_FILL || state == S_DRAIN) && flush) begin
                    flush_seen <= 1'b1;
                end
            end
            cw_valid <= fill_beat && (beat_cnt == '0) && !flush_seen && !flush;
            if (fill_beat && (beat_cnt == '0)) begin
                cw_word <= mem_data;
            end
            if (state == S_IDLE && state_n == S_INV) begin
                inv_pend <= 1'b0;
            end else if (inv_req) begin
                inv_pend <= 1'b1;
            end
            if (state == S_INV) begin
                inv_idx <= inv_idx + IDX_W'(1);
            end
            if (inv_last) begin
                inv_quiet <= 1'b0;
            end
        end
    end

    // Array read port
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            tag_rd[w]   <= tag_mem[w][idx1];
            valid_rd[w] <= valid_mem[w][idx1];
            data_rd[w]  <= data_mem[w][{idx1, off1}];
        end
    end

    // Array writes: fill into the victim way, invalidate sweep clears one index per cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++) begin
                if (fill_beat && icache_on && victim[w]) begin
                    data_mem[w][{idx2, wr_off}] <= mem_data;
                    if (fill_last) begin
                        tag_mem[w][idx2]   <= tag2;
                        valid_mem[w][idx2] <= 1'b1;
                    end
                end
                if (state == S_INV) begin
                    valid_mem[w][inv_idx] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_cwf.sv
// tb/tb_icache_cwf.sv - scoreboard bench for icache_cwf
module tb_icache_cwf;
    localparam int WAYS   = 2;
    localparam int LINES  = 16;
    localparam int LINE_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_on;
    logic        new_request;
    logic [31:0] stage1_addr;
    logic [31:0] stage2_addr;
    logic        flush;
    logic        inv_req;
    logic        inv_done;
    logic [31:0] data_out;
    logic        data_valid;
    logic        ready;
    logic        mem_request;
    logic [31:0] mem_addr;
    logic [4:0]  mem_size;
    logic        mem_ack;
    logic        mem_data_valid;
    logic [31:0] mem_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    // Reference model: victim rotation and resident line base addresses
    logic [WAYS-1:0] vic_m;
    logic [WAYS-1:0] vic_prev;
    bit              m_valid [WAYS][LINES];
    logic [31:0]     m_line  [WAYS][LINES];

    always #5 clk = ~clk;

    icache_cwf #(.WAYS(WAYS), .LINES(LINES), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst), .icache_on(icache_on), .new_request(new_request),
        .stage1_addr(stage1_addr), .stage2_addr(stage2_addr), .flush(flush),
        .inv_req(inv_req), .inv_done(inv_done), .data_out(data_out),
        .data_valid(data_valid), .ready(ready), .mem_request(mem_request),
        .mem_addr(mem_addr), .mem_size(mem_size), .mem_ack(mem_ack),
        .mem_data_valid(mem_data_valid), .mem_data(mem_data)
    );

    always @(posedge clk) begin
        vic_prev <= vic_m;
        if (rst) vic_m <= WAYS'(1);
        else     vic_m <= {vic_m[WAYS-2:0], vic_m[WAYS-1]};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[w][a[7:4]] && m_line[w][a[7:4]] == {a[31:4], 4'h0}) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_ready(input string name);
        int waited = 0;
        @(negedge clk);
        while (ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_wait: ready=%b required 1", name, ready);
        end
    endtask

    // One fetch with a responding memory; expectations come from the model
    task automatic fetch(input logic [31:0] addr, input bit flush_in_req, input int flush_at, input string name);
        bit exp_hit, deliver, saw_req, acked, got, done;
        bit s_dv, s_rdy, s_req;
        logic [31:0] s_do, exp, wa;
        logic [WAYS-1:0] vic_seen;
        int lat, beat;
        exp_hit = icache_on && model_hit(addr);
        deliver = !flush_in_req && flush_at < 0;
        wait_ready(name);
        new_request = 1'b1;
        stage1_addr = addr;
        stage2_addr = addr;
        if (deliver) exp_q.push_back(mem_word(addr));
        lat = -1; saw_req = 0; acked = 0; beat = 0; got = 0; done = 0; vic_seen = '0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            s_dv = data_valid; s_do = data_out; s_rdy = ready; s_req = mem_request;
            new_request = 1'b0; flush = (cyc == flush_at); mem_ack = 1'b0; mem_data_valid = 1'b0;
            if (s_dv) begin
                got = 1; lat = cyc;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s unexpected_data: data_out=%h with nothing expected", name, s_do);
                end else begin
                    exp = exp_q.pop_front();
                    if (s_do !== exp) begin
                        n_fail++;
                        $display("FAIL %s data: data_out=%h required %h", name, s_do, exp);
                    end
                end
            end
            if (s_req && !acked) begin
                if (!saw_req) begin
                    saw_req = 1; vic_seen = vic_prev;
                    n_checks++;
                    if (mem_addr !== {addr[31:2], 2'b00} || mem_size !== 5'(LINE_W - 1)) begin
                        n_fail++;
                        $display("FAIL %s mem_addr: addr=%h size=%0d required %h size %0d",
                                 name, mem_addr, mem_size, {addr[31:2], 2'b00}, LINE_W - 1);
                    end
                end
                if (flush_in_req) begin
                    flush = 1'b1;
                    #1;
                    n_checks++;
                    if (mem_request !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s req_drop: mem_request=%b required 0", name, mem_request);
                    end
                end else begin
                    mem_ack = 1'b1;
                    acked = 1;
                end
            end else if (acked && beat < LINE_W) begin
                wa = {addr[31:4], 4'h0} | 32'((((addr[3:2] + beat) % LINE_W)) << 2);
                mem_data_valid = 1'b1;
                mem_data = mem_word(wa);
                beat++;
            end
            if (s_rdy) done = 1;
        end
        mem_ack = 1'b0; mem_data_valid = 1'b0; flush = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: ready=%b required 1 within 60 cycles", name, ready);
        end
        n_checks++;
        if (saw_req == exp_hit) begin
            n_fail++;
            $display("FAIL %s path: mem_request seen=%0d required %0d", name, saw_req, !exp_hit);
        end
        n_checks++;
        if (got != deliver) begin
            n_fail++;
            $display("FAIL %s delivery: data_valid seen=%0d required %0d", name, got, deliver);
        end
        if (deliver) begin
            n_checks++;
            if (lat != (exp_hit ? 1 : 4)) begin
                n_fail++;
                $display("FAIL %s latency: %0d cycles after issue, required %0d", name, lat, exp_hit ? 1 : 4);
            end
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s leftover: %0d expected words never delivered", name, exp_q.size());
            exp_q.delete();
        end
        if (saw_req && !flush_in_req && icache_on) begin
            for (int w = 0; w < WAYS; w++) begin
                if (vic_seen[w]) begin
                    m_valid[w][addr[7:4]] = 1'b1;
                    m_line[w][addr[7:4]]  = {addr[31:4], 4'h0};
                end
            end
        end
    endtask

    task automatic count_sweep(input string name);
        int low = 0;
        int dones = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            inv_req = 1'b0;
            if (inv_done === 1'b1) dones++;
            if (ready === 1'b1) break;
            low++;
        end
        n_checks++;
        if (low != LINES) begin
            n_fail++;
            $display("FAIL %s ready_low: %0d cycles required %0d", name, low, LINES);
        end
        n_checks++;
        if (dones != (name == "inv" ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s inv_done: %0d pulses required %0d", name, dones, name == "inv" ? 1 : 0);
        end
        for (int w = 0; w < WAYS; w++)
            for (int i = 0; i < LINES; i++) m_valid[w][i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ready !== 1'b0 || data_valid !== 1'b0 || mem_request !== 1'b0 || inv_done !== 1'b0 || data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b dv=%b req=%b done=%b do=%h required all 0",
                     ready, data_valid, mem_request, inv_done, data_out);
        end
        rst = 1'b0;
        @(posedge clk);
        count_sweep("reset");
    endtask

    task automatic test_cold_miss();
        fetch(32'h1008, 0, -1, "cold_1008");
        fetch(32'h1000, 0, -1, "hit_1000");
        fetch(32'h100C, 0, -1, "hit_100c");
        fetch(32'h1004, 0, -1, "hit_1004");
    endtask

    task automatic test_flush_fill();
        fetch(32'h1048, 0, 3, "flush_fill_1048");
        fetch(32'h1048, 0, -1, "after_flush_1048");
    endtask

    task automatic test_flush_req();
        fetch(32'h1088, 1, -1, "flush_req_1088");
        fetch(32'h1088, 0, -1, "refetch_1088");
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        wait_ready("b2b");
        new_request = 1'b1; stage1_addr = 32'h1048; stage2_addr = 32'h1048;
        exp_q.push_back(mem_word(32'h1048));
        @(negedge clk);
        exp = exp_q.pop_front();
        n_checks++;
        if (data_valid !== 1'b1 || ready !== 1'b1 || data_out !== exp) begin
            n_fail++;
            $display("FAIL b2b_first: dv=%b ready=%b data=%h required 1 1 %h", data_valid, ready, data_out, exp);
        end
        stage1_addr = 32'h1040;
        exp_q.push_back(mem_word(32'h1040));
        @(posedge clk);
        #1;
        stage2_addr = 32'h1040;
        new_request = 1'b0;
        @(negedge clk);
        exp = exp_q.pop_front();
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== exp) begin
            n_fail++;
            $display("FAIL b2b_second: dv=%b data=%h required 1 %h", data_valid, data_out, exp);
        end
    endtask

    task automatic test_evict();
        fetch(32'h2000, 0, -1, "evict_fill_2000");
        fetch(32'h3000, 0, -1, "evict_fill_3000");
        fetch(32'h1008, 0, -1, "evict_probe_1008");
        fetch(32'h3008, 0, -1, "evict_probe_3008");
        fetch(32'h2008, 0, -1, "evict_probe_2008");
    endtask

    task automatic test_off();
        icache_on = 1'b0;
        fetch(32'h2000, 0, -1, "off_2000_a");
        fetch(32'h2000, 0, -1, "off_2000_b");
        icache_on = 1'b1;
    endtask

    task automatic test_inv();
        fetch(32'h1048, 0, -1, "pre_inv_1048");
        wait_ready("inv");
        inv_req = 1'b1;
        count_sweep("inv");
        fetch(32'h1048, 0, -1, "post_inv_1048");
        fetch(32'h1044, 0, -1, "post_inv_1044");
    endtask

    initial begin
        rst = 1'b1; icache_on = 1'b1; new_request = 1'b0; stage1_addr = '0; stage2_addr = '0;
        flush = 1'b0; inv_req = 1'b0; mem_ack = 1'b0; mem_data_valid = 1'b0; mem_data = '0;
        for (int w = 0; w < WAYS; w++)
            for (int i = 0; i < LINES; i++) begin
                m_valid[w][i] = 1'b0;
                m_line[w][i]  = '0;
            end
        test_reset();
        test_cold_miss();
        test_flush_fill();
        test_flush_req();
        test_back_to_back();
        test_evict();
        test_off();
        test_inv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
